// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_pkg : shared encodings for the UART transmit path               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_parity_calc : even/odd parity of a WIDTH-bit word (TX and RX)      |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             par_bit
);

  // Odd parity is the complement of even parity (XNOR-reduce).
  always_comb begin
    par_bit = (^data) ^ (par_typ == PAR_ODD);
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_ctrl : UART transmit frame sequencer (start/data/parity/stop)   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DATA_VALID,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             ser_data,
  output logic             ser_en,
  output logic             busy,
  output logic             TX_OUT
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             par_en_q, par_en_d;
  logic             par_typ_q, par_typ_d;
  logic             accept;
  logic             par_bit;

  // New frames are only taken from IDLE or STOP; anything else is dropped.
  assign accept = DATA_VALID && ((state_q == IDLE) || (state_q == STOP));

  uart_parity_calc #(
    .WIDTH (WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;

    case (state_q)
      IDLE:    if (DATA_VALID) state_d = START;
      START:   state_d = DATA;
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = DATA_VALID ? START : IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
    end
  end

  always_comb begin
    ser_en = 1'b0;
    busy   = 1'b0;
    TX_OUT = STOP_BIT;
    case (state_q)
      START: begin
        ser_en = 1'b1;
        busy   = 1'b1;
        TX_OUT = START_BIT;
      end
      DATA: begin
        busy   = 1'b1;
        TX_OUT = ser_data;
      end
      PARITY: begin
        busy   = 1'b1;
        TX_OUT = par_bit;
      end
      STOP: begin
        busy   = 1'b1;
        TX_OUT = STOP_BIT;
      end
      default: begin
        ser_en = 1'b0;
        busy   = 1'b0;
        TX_OUT = STOP_BIT;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_ctrl : directed frame checks for uart_tx_ctrl                 |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       DATA_VALID = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_data;
  logic       ser_en;
  logic       busy;
  logic       TX_OUT;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic       exp_par;
  } frame_vec_t;

  frame_vec_t vecs[6];

  uart_tx_ctrl #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_VALID (DATA_VALID),
    .P_DATA     (P_DATA),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT)
  );

  always #5 CLK = ~CLK;

  // Serializer model: loads on the edge that ends START, then shifts LSB-first.
  logic [7:0] ser_shreg = 8'h00;
  always @(posedge CLK) begin
    if (ser_en) ser_shreg <= P_DATA;
    else        ser_shreg <= {1'b0, ser_shreg[7:1]};
  end
  assign ser_data = ser_shreg[0];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk_out(input string tag, input logic tx, input logic b, input logic se);
    chk({tag, ".TX_OUT"}, TX_OUT, tx);
    chk({tag, ".busy"},   busy,   b);
    chk({tag, ".ser_en"}, ser_en, se);
  endtask

  // Entered in the START cycle; returns in the STOP cycle.
  task automatic run_frame(input logic [7:0] d, input logic en, input logic typ,
                           input logic exp_par, input logic mid_pulse);
    chk_out("start", 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        P_DATA  = ~d;
        PAR_EN  = ~en;
        PAR_TYP = ~typ;
      end
      if (mid_pulse && k == 2) DATA_VALID = 1'b1;
      if (mid_pulse && k == 3) DATA_VALID = 1'b0;
      chk_out($sformatf("data%0d", k), d[k], 1'b1, 1'b0);
    end
    if (en) begin
      tick();
      chk_out("parity", exp_par, 1'b1, 1'b0);
    end
    tick();
    chk_out("stop", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input logic en, input logic typ);
    P_DATA     = d;
    PAR_EN     = en;
    PAR_TYP    = typ;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{data: 8'hA5, par_en: 1'b1, par_typ: 1'b0, exp_par: 1'b0};
    vecs[1] = '{data: 8'hA5, par_en: 1'b1, par_typ: 1'b1, exp_par: 1'b1};
    vecs[2] = '{data: 8'hA5, par_en: 1'b0, par_typ: 1'b0, exp_par: 1'b0};
    vecs[3] = '{data: 8'h3C, par_en: 1'b1, par_typ: 1'b1, exp_par: 1'b1};
    vecs[4] = '{data: 8'h01, par_en: 1'b1, par_typ: 1'b0, exp_par: 1'b1};
    vecs[5] = '{data: 8'h00, par_en: 1'b1, par_typ: 1'b1, exp_par: 1'b1};

    RST = 1'b0;
    repeat (3) tick();
    chk_out("reset", 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("idle", 1'b1, 1'b0, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].par_en, vecs[i].par_typ);
      run_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].exp_par, 1'b0);
      tick();
      chk_out("post_idle", 1'b1, 1'b0, 1'b0);
    end

    // DATA_VALID during DATA must neither alter this frame nor queue another.
    send(8'hA5, 1'b1, 1'b0);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("no_queue0", 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("no_queue1", 1'b1, 1'b0, 1'b0);

    // Back-to-back frames with DATA_VALID held high.
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick();
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    tick();
    run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    DATA_VALID = 1'b0;
    tick();
    chk_out("b2b_idle", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset during data bit 3 (0xA5 bit 3 is 0).
    send(8'hA5, 1'b1, 1'b0);
    chk_out("rst_start", 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    chk("rst_bit3.TX_OUT", TX_OUT, 1'b0);
    #2 RST = 1'b0;
    #1 chk_out("rst_async", 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("rst_held", 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rst_no_resume", 1'b1, 1'b0, 1'b0);
    end
    send(8'h01, 1'b1, 1'b0);
    run_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("rst_final_idle", 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
